// File: rtl/oclib_uart_rx.sv
// oclib_uart_rx: 8N1 UART receiver with a mid-bit sampling FSM and a small output FIFO.
//
// Parameters:
//   ClockHz    clock frequency in Hz
//   Baud       line rate; BitCycles = round(ClockHz / Baud), must be >= 8
//   FifoDepth  output FIFO entries (power of 2, 2..64)
//   SyncCycles rx synchronizer depth (>= 2)
//
// Ports:
//   clock        sole clock
//   resetn       asynchronous active-low reset
//   rx           asynchronous serial input, idles high
//   outData      head-of-FIFO byte
//   outValid     FIFO not empty
//   outReady     consumer accepts outData when outValid && outReady
//   busy         receiver FSM not idle
//   frameError   one-cycle pulse on a bad stop bit
//   overflow     sticky, set when a byte is dropped on a full FIFO
//   clearErrors  synchronous clear of overflow
//
// Optional feature macro: OCLIB_UART_RX_MAJORITY_EN
//   When defined, each start/data/stop sample is the 2-of-3 majority of rxS taken
//   at counter values 1, 0 and BitCycles-1; the FSM acts on it one cycle later.

module oclib_uart_rx #(
    parameter int unsigned ClockHz    = 100000000,
    parameter int unsigned Baud       = 115200,
    parameter int unsigned FifoDepth  = 4,
    parameter int unsigned SyncCycles = 2
) (
    input  logic       clock,
    input  logic       resetn,
    input  logic       rx,
    output logic [7:0] outData,
    output logic       outValid,
    input  logic       outReady,
    output logic       busy,
    output logic       frameError,
    output logic       overflow,
    input  logic       clearErrors
);

    localparam int unsigned BitCycles  = (ClockHz + Baud / 2) / Baud;
    localparam int unsigned HalfCycles = BitCycles / 2;
    localparam int unsigned CntW       = $clog2(BitCycles);
    localparam int unsigned PtrW       = $clog2(FifoDepth);
    localparam logic [CntW-1:0] BitLoad  = CntW'(BitCycles - 1);
    localparam logic [CntW-1:0] HalfLoad = CntW'(HalfCycles - 1);

    if (BitCycles < 8) begin : g_bad_baud
        $error("oclib_uart_rx: BitCycles must be at least 8");
    end
    if (FifoDepth < 2 || FifoDepth > 64 || (FifoDepth & (FifoDepth - 1)) != 0) begin : g_bad_depth
        $error("oclib_uart_rx: FifoDepth must be a power of 2 in 2..64");
    end
    if (SyncCycles < 2) begin : g_bad_sync
        $error("oclib_uart_rx: SyncCycles must be at least 2");
    end

    // ---------------- rx synchronizer ----------------
    logic [SyncCycles-1:0] r_sync;
    logic                  w_rxS;

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) r_sync <= '1;
        else         r_sync <= {r_sync[SyncCycles-2:0], rx};
    end
    assign w_rxS = r_sync[SyncCycles-1];

    // ---------------- receive FSM ----------------
    typedef enum logic [2:0] {ST_IDLE, ST_START, ST_DATA, ST_STOP, ST_BRK} state_t;

    state_t          r_state;
    logic [CntW-1:0] r_cnt;
    logic [2:0]      r_bitIdx;
    logic [7:0]      r_shift;
    logic            r_frameErr;
    logic            w_sampling;
    logic            w_cntZero;
    logic            w_decide;
    logic            w_bit;
    logic            w_push;

    assign w_sampling = r_state inside {ST_START, ST_DATA, ST_STOP};
    assign w_cntZero  = (r_cnt == '0);

`ifdef OCLIB_UART_RX_MAJORITY_EN
    logic r_s1;
    logic r_s0;
    logic r_pend;

    // The counter keeps running through the third-sample cycle, so bit timing
    // is identical to the single-sample build; only the decision is deferred.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            r_s1   <= 1'b1;
            r_s0   <= 1'b1;
            r_pend <= 1'b0;
        end else begin
            if (w_sampling && r_cnt == CntW'(1)) r_s1 <= w_rxS;
            if (w_sampling && w_cntZero)         r_s0 <= w_rxS;
            r_pend <= w_sampling && w_cntZero;
        end
    end
    assign w_decide = r_pend;
    assign w_bit    = (r_s1 & r_s0) | (r_s1 & w_rxS) | (r_s0 & w_rxS);
`else
    assign w_decide = w_sampling && w_cntZero;
    assign w_bit    = w_rxS;
`endif

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            r_state    <= ST_IDLE;
            r_cnt      <= '0;
            r_bitIdx   <= '0;
            r_shift    <= '0;
            r_frameErr <= 1'b0;
        end else begin
            r_frameErr <= 1'b0;
            if (w_sampling) r_cnt <= w_cntZero ? BitLoad : r_cnt - 1'b1;
            case (r_state)
                ST_IDLE: begin
                    if (!w_rxS) begin
                        r_state <= ST_START;
                        r_cnt   <= HalfLoad;
                    end
                end
                ST_START: begin
                    if (w_decide) begin
                        if (w_bit) begin
                            r_state <= ST_IDLE;
                        end else begin
                            r_state  <= ST_DATA;
                            r_bitIdx <= '0;
                        end
                    end
                end
                ST_DATA: begin
                    if (w_decide) begin
                        r_shift[r_bitIdx] <= w_bit;
                        r_bitIdx          <= r_bitIdx + 1'b1;
                        if (r_bitIdx == 3'd7) r_state <= ST_STOP;
                    end
                end
                ST_STOP: begin
                    if (w_decide) begin
                        if (w_bit) begin
                            r_state <= ST_IDLE;
                        end else begin
                            r_frameErr <= 1'b1;
                            r_state    <= ST_BRK;
                        end
                    end
                end
                ST_BRK: begin
                    // Held-low line: wait for idle so a break yields no 0x00 bytes.
                    if (w_rxS) r_state <= ST_IDLE;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign w_push = (r_state == ST_STOP) && w_decide && w_bit;

    // ---------------- output FIFO ----------------
    logic [7:0]      r_mem [FifoDepth];
    logic [PtrW-1:0] r_rdPtr;
    logic [PtrW-1:0] r_wrPtr;
    logic [PtrW:0]   r_count;
    logic [7:0]      r_head;
    logic            r_overflow;
    logic            w_full;
    logic            w_pop;
    logic            w_accept;
    logic [PtrW-1:0] w_rdNext;

    assign w_full   = (r_count == (PtrW + 1)'(FifoDepth));
    assign w_pop    = (r_count != '0) && outReady;
    assign w_accept = w_push && (!w_full || w_pop);
    assign w_rdNext = r_rdPtr + 1'b1;

    always_ff @(posedge clock) begin
        if (w_accept) r_mem[r_wrPtr] <= r_shift;
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            r_rdPtr    <= '0;
            r_wrPtr    <= '0;
            r_count    <= '0;
            r_head     <= '0;
            r_overflow <= 1'b0;
        end else begin
            if (w_accept) r_wrPtr <= r_wrPtr + 1'b1;
            if (w_pop)    r_rdPtr <= w_rdNext;

            case ({w_accept, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase

            // Head register tracks the entry that will be at the read pointer next
            // cycle; a byte pushed into an empty (or emptying) FIFO bypasses memory.
            if (w_pop) begin
                if (r_count > (PtrW + 1)'(1)) r_head <= r_mem[w_rdNext];
                else if (w_accept)            r_head <= r_shift;
            end else if (r_count == '0 && w_accept) begin
                r_head <= r_shift;
            end

            // A drop in the same cycle as clearErrors leaves overflow set.
            if (w_push && !w_accept) r_overflow <= 1'b1;
            else if (clearErrors)    r_overflow <= 1'b0;
        end
    end

    assign outData    = r_head;
    assign outValid   = (r_count != '0);
    assign busy       = (r_state != ST_IDLE);
    assign frameError = r_frameErr;
    assign overflow   = r_overflow;

endmodule

// File: doc/oclib_uart_rx.md
Name: oclib_uart_rx

Overview:
- Synthesizable 8N1 UART receiver; the DUT-side stage that consumes the serial stream driven by the ocsim UART model's tx pin.
- Recovers bytes by mid-bit sampling and buffers them in a small FIFO.
- Presents bytes on a valid/ready interface to the downstream command/CSR logic.
- Flags framing errors and overflow.

Parameters:
- ClockHz, 100000000, clock frequency in Hz.
- Baud, 115200, line rate. BitCycles = (ClockHz + Baud/2) / Baud, rounded to nearest. HalfCycles = BitCycles / 2. Elaboration error if BitCycles < 8.
- FifoDepth, 4, output FIFO entries; power of 2, range 2 to 64.
- SyncCycles, 2, rx synchronizer flops; minimum 2.

Ports:
- clock  input  1  sole clock.
- resetn  input  1  asynchronous, active-low reset.
- rx  input  1  asynchronous serial input; idles high.
- outData  output  8  head-of-FIFO byte.
- outValid  output  1  FIFO not empty.
- outReady  input  1  consumer accepts outData when outValid && outReady.
- busy  output  1  FSM not in IDLE.
- frameError  output  1  single-cycle pulse on a bad stop bit.
- overflow  output  1  sticky; set when a byte is dropped because the FIFO is full.
- clearErrors  input  1  synchronous clear of overflow.

Behaviour:
- Reset (resetn=0, asynchronous):
  - Synchronizer flops set to 1.
  - FSM goes to IDLE; FIFO is empty; bit counter and cycle counter are 0.
  - outValid=0, outData=0, busy=0, frameError=0, overflow=0.
- rxS is rx after SyncCycles flops. All decisions use rxS only.
- IDLE: when rxS==0, go to START and load the cycle counter with HalfCycles-1.
- START: the counter decrements each cycle. At 0, sample rxS:
  - rxS==1 means a glitch; return to IDLE and push nothing.
  - rxS==0: go to DATA, load the counter with BitCycles-1, set bitIdx=0.
- DATA: at counter 0, sample rxS into shift[bitIdx] (LSB first) and reload BitCycles-1. After bitIdx 7, go to STOP.
- STOP: at counter 0, sample rxS:
  - rxS==1: push the byte and go to IDLE.
  - rxS==0: pulse frameError for 1 cycle, push nothing, go to BRK.
- BRK: wait for rxS==1, then go to IDLE. This prevents a held-low line (break) from producing 0x00 bytes.
- busy=1 in START, DATA, STOP and BRK.
- Latency: outValid rises the cycle after the STOP sample cycle when the FIFO was empty. outData is valid in the same cycle.
- FIFO rules:
  - Read pointer, write pointer and count registers; outData comes from a registered head.
  - Pop occurs when outValid && outReady.
  - Push while full with no pop in the same cycle: drop the byte and set overflow.
  - Push while full with a simultaneous pop: accept the push and leave overflow unchanged.
  - Push and pop together when count==1: count stays 1 and outData becomes the new byte.
  - Pointers wrap modulo FifoDepth.
- Errors:
  - clearErrors clears overflow.
  - If clearErrors coincides with a drop, overflow remains set.
  - frameError is never sticky.
- Back-to-back frames: IDLE re-arms in the cycle after the STOP sample, so a start edge arriving half a bit after the stop sample is caught.
- Reset mid-frame: the partial byte is discarded and the FIFO contents are lost.

Optional Feature:
- Macro: OCLIB_UART_RX_MAJORITY_EN.
- When defined, each START, DATA and STOP sample is the 2-of-3 majority of rxS at counter values 1, 0 and BitCycles-1 (the last taken one cycle later). The FSM advances one cycle after the third sample. All other timing is unchanged, including the outValid latency of +1 cycle.
- When undefined, each sample is the single rxS value at counter 0, as described above.

Test Plan:
- Use ClockHz=100e6, Baud=10e6 (BitCycles=10) throughout; ocsim UART model tx drives rx; outReady=1.
- Send 0x55 then 0xA3: outData shows 0x55 then 0xA3, each with one outValid cycle; frameError=0, overflow=0.
- Drive rx low for 3 cycles, then high: no outValid; busy pulses and then returns to 0.
- Send 0x3C with the stop bit forced low for 2 bit times: frameError pulses exactly once, no byte is pushed, FSM returns to IDLE after rx goes high.
- outReady=0, send 0x01..0x05: overflow=1. Then outReady=1: drains 0x01..0x04 only. Pulse clearErrors: overflow=0.
- Assert resetn low during bit 4 of 0x7E, release it, then send 0x81: only 0x81 is received.
- Send 16 back-to-back bytes 0x00..0x0F with the stop bit at exactly 1 bit time: all 16 are received in order with no errors.
